// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store push, load forwarding lookup,
// memory write port and occupancy status.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;

  logic          mem_grant;
  logic          mem_ack;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_grant, mem_ack,
    input  st_ready, ld_hit, ld_data, mem_en, mem_wr, mem_addr, mem_data,
           empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_grant, mem_ack,
    output st_ready, ld_hit, ld_data, mem_en, mem_wr, mem_addr, mem_data,
           empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Write-through store buffer: in-order FIFO of pending stores, drained to
// main memory one write at a time, with youngest-match load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic          ready, push, pop, write_en;
  logic          hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign ready = (cnt != FULL);
  assign push  = bus.st_valid && ready;
  assign pop   = (state == WRITE) && bus.mem_ack;

  // Drain FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Drain FSM next-state and memory enable
  always_comb begin
    state_nx = state;
    write_en = 1'b0;
    case (state)
      IDLE:  if ((cnt != '0) && bus.mem_grant) state_nx = WRITE;
      WRITE: begin
        write_en = 1'b1;
        if (bus.mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pointers, occupancy and entry valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload storage (qualified by valid_q, so no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= bus.st_addr;
      data_q[tail] <= bus.st_data;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overrides
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid_q[idx] && (addr_q[idx][AW-1:1] == bus.ld_addr[AW-1:1])) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
    if (!bus.ld_valid) begin
      hit      = 1'b0;
      fwd_data = '0;
    end
  end

  assign bus.st_ready = ready;
  assign bus.ld_hit   = hit;
  assign bus.ld_data  = fwd_data;
  assign bus.mem_en   = write_en;
  assign bus.mem_wr   = write_en;
  assign bus.mem_addr = write_en ? addr_q[head] : '0;
  assign bus.mem_data = write_en ? data_q[head] : '0;
  assign bus.empty    = (cnt == '0);
  assign bus.count    = cnt;
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic idle_inputs();
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.mem_grant = 1'b0;
    bus.mem_ack   = 1'b0;
  endtask

  // One-cycle store push; returns on the negedge after the push edge
  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    @(negedge clk);
    bus.st_valid = 1'b0;
  endtask

  // Grant and acknowledge until the buffer is empty (bounded)
  task automatic drain_all();
    bit done;
    done = 1'b0;
    bus.mem_grant = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.count == 0 && !bus.mem_en) begin
        done = 1'b1;
        break;
      end
      bus.mem_ack = bus.mem_en;
    end
    bus.mem_ack   = 1'b0;
    bus.mem_grant = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL drain_timeout: got count=%0d required 0", bus.count); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    checks++; if (bus.count !== 0)      begin errors++; $display("FAIL rst_count: got %0d required 0", bus.count); end
    checks++; if (bus.empty !== 1'b1)   begin errors++; $display("FAIL rst_empty: got %b required 1", bus.empty); end
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", bus.st_ready); end
    checks++; if (bus.mem_en !== 1'b0 || bus.mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got en=%b wr=%b required 0", bus.mem_en, bus.mem_wr); end
    checks++; if (bus.mem_addr !== 16'h0 || bus.mem_data !== 16'h0) begin errors++; $display("FAIL rst_mem_bus: got %h/%h required 0000/0000", bus.mem_addr, bus.mem_data); end
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0000; #1;
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 16'h0) begin errors++; $display("FAIL rst_fwd: got hit=%b data=%h required 0/0000", bus.ld_hit, bus.ld_data); end
    bus.ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_drain();
    bus.mem_grant = 1'b1;
    push_one(16'h0010, 16'hAAAA);
    checks++; if (bus.count !== 1)     begin errors++; $display("FAIL single_count1: got %0d required 1", bus.count); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL single_en_early: got %b required 0", bus.mem_en); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1) begin errors++; $display("FAIL single_en[%0d]: got en=%b wr=%b required 1", c, bus.mem_en, bus.mem_wr); end
      checks++; if (bus.mem_addr !== 16'h0010 || bus.mem_data !== 16'hAAAA) begin errors++; $display("FAIL single_bus[%0d]: got %h/%h required 0010/aaaa", c, bus.mem_addr, bus.mem_data); end
    end
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0011; #1;
    checks++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 16'hAAAA) begin errors++; $display("FAIL single_fwd_head: got hit=%b data=%h required 1/aaaa", bus.ld_hit, bus.ld_data); end
    bus.ld_valid = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.mem_grant = 1'b0;
    checks++; if (bus.count !== 0 || bus.empty !== 1'b1) begin errors++; $display("FAIL single_count0: got count=%0d empty=%b required 0/1", bus.count, bus.empty); end
    checks++; if (bus.mem_en !== 1'b0 || bus.mem_addr !== 16'h0) begin errors++; $display("FAIL single_en_off: got en=%b addr=%h required 0/0000", bus.mem_en, bus.mem_addr); end
  endtask

  task automatic test_fill_drain();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = AW'(2 * i);
      d = DW'(16'h0100 + i);
      push_one(a, d);
    end
    checks++; if (bus.count !== 4 || bus.st_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count=%0d ready=%b required 4/0", bus.count, bus.st_ready); end
    push_one(16'h0008, 16'hDEAD);
    checks++; if (bus.count !== 4) begin errors++; $display("FAIL fill_fifth: got %0d required 4", bus.count); end
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0008; #1;
    checks++; if (bus.ld_hit !== 1'b0) begin errors++; $display("FAIL fill_fifth_fwd: got hit=%b required 0", bus.ld_hit); end
    bus.ld_valid = 1'b0;
    bus.mem_grant = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a = AW'(2 * k);
      d = DW'(16'h0100 + k);
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== a || bus.mem_data !== d) begin errors++; $display("FAIL drain_order[%0d]: got en=%b %h/%h required 1 %h/%h", k, bus.mem_en, bus.mem_addr, bus.mem_data, a, d); end
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if (bus.mem_en !== 1'b0 || bus.count !== 3 - k) begin errors++; $display("FAIL drain_gap[%0d]: got en=%b count=%0d required 0/%0d", k, bus.mem_en, bus.count, 3 - k); end
      if (k < 3) @(negedge clk);
    end
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL drain_extra: got en=%b required 0", bus.mem_en); end
    bus.mem_grant = 1'b0;
  endtask

  task automatic test_forward();
    push_one(16'h0020, 16'h1111);
    push_one(16'h0020, 16'h2222);
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0021; #1;
    checks++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 16'h2222) begin errors++; $display("FAIL fwd_youngest: got hit=%b data=%h required 1/2222", bus.ld_hit, bus.ld_data); end
    bus.ld_addr = 16'h0030; #1;
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 16'h0) begin errors++; $display("FAIL fwd_miss: got hit=%b data=%h required 0/0000", bus.ld_hit, bus.ld_data); end
    bus.ld_valid = 1'b0; bus.ld_addr = 16'h0020; #1;
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 16'h0) begin errors++; $display("FAIL fwd_novalid: got hit=%b data=%h required 0/0000", bus.ld_hit, bus.ld_data); end
    bus.mem_grant = 1'b1;
    @(negedge clk);
    bus.mem_grant = 1'b0;
    checks++; if (bus.mem_addr !== 16'h0020 || bus.mem_data !== 16'h1111) begin errors++; $display("FAIL fwd_drain_first: got %h/%h required 0020/1111", bus.mem_addr, bus.mem_data); end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0020; #1;
    checks++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 16'h2222 || bus.count !== 1) begin errors++; $display("FAIL fwd_after_pop: got hit=%b data=%h count=%0d required 1/2222/1", bus.ld_hit, bus.ld_data, bus.count); end
    bus.ld_valid = 1'b0;
    drain_all();
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) push_one(AW'(16'h0040 + 2 * i), DW'(16'h4000 + i));
    bus.mem_grant = 1'b1;
    @(negedge clk);
    bus.mem_grant = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.st_valid = 1'b1; bus.st_addr = 16'h0048; bus.st_data = 16'h5555;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++; if (bus.count !== 3 || bus.st_ready !== 1'b1) begin errors++; $display("FAIL full_push_rejected: got count=%0d ready=%b required 3/1", bus.count, bus.st_ready); end
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.count !== 4 || bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_push_next: got count=%0d ready=%b required 4/0", bus.count, bus.st_ready); end
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0048; #1;
    checks++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 16'h5555) begin errors++; $display("FAIL full_fwd_new: got hit=%b data=%h required 1/5555", bus.ld_hit, bus.ld_data); end
    bus.ld_addr = 16'h0040; #1;
    checks++; if (bus.ld_hit !== 1'b0) begin errors++; $display("FAIL full_fwd_popped: got hit=%b required 0", bus.ld_hit); end
    bus.ld_valid = 1'b0;
    drain_all();
    push_one(16'h0070, 16'h7070);
    push_one(16'h0072, 16'h7272);
    bus.mem_grant = 1'b1;
    @(negedge clk);
    bus.mem_grant = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.st_valid = 1'b1; bus.st_addr = 16'h0074; bus.st_data = 16'h7474;
    @(negedge clk);
    bus.mem_ack  = 1'b0;
    bus.st_valid = 1'b0;
    checks++; if (bus.count !== 2 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL simul_count2: got count=%0d en=%b required 2/0", bus.count, bus.mem_en); end
    drain_all();
  endtask

  task automatic test_grant_drop();
    push_one(16'h0060, 16'h6666);
    push_one(16'h0062, 16'h6262);
    bus.mem_grant = 1'b1;
    @(negedge clk);
    bus.mem_grant = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0060 || bus.mem_data !== 16'h6666) begin errors++; $display("FAIL drop_hold[%0d]: got en=%b %h/%h required 1 0060/6666", c, bus.mem_en, bus.mem_addr, bus.mem_data); end
      @(negedge clk);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.mem_en !== 1'b0 || bus.count !== 1) begin errors++; $display("FAIL drop_idle[%0d]: got en=%b count=%0d required 0/1", c, bus.mem_en, bus.count); end
      @(negedge clk);
    end
    drain_all();
  endtask

  task automatic test_reset_write();
    push_one(16'h0080, 16'h8080);
    push_one(16'h0082, 16'h8282);
    bus.mem_grant = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL rw_started: got en=%b required 1", bus.mem_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_en !== 1'b0 || bus.mem_wr !== 1'b0) begin errors++; $display("FAIL rw_en_drop: got en=%b wr=%b required 0", bus.mem_en, bus.mem_wr); end
    checks++; if (bus.count !== 0 || bus.empty !== 1'b1 || bus.st_ready !== 1'b1) begin errors++; $display("FAIL rw_status: got count=%0d empty=%b ready=%b required 0/1/1", bus.count, bus.empty, bus.st_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.mem_en !== 1'b0 || bus.count !== 0) begin errors++; $display("FAIL rw_no_write[%0d]: got en=%b count=%0d required 0/0", c, bus.mem_en, bus.count); end
    end
    bus.mem_grant = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_fill_drain();
    test_forward();
    test_full_simul();
    test_grant_drop();
    test_reset_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-through store buffer between the MEM stage and main memory. It queues up to DEPTH stores (address/data) so a store retiring from EX/MEM does not stall while main memory is busy with cache fills. It drains entries in order to main memory whenever the memory arbiter grants the write port. It also forwards the youngest matching buffered store to MEM-stage loads so they never read stale memory.

## Interface
- DEPTH, 4, number of entries; power of 2, ≥ 2
- AW, 16, address width
- DW, 16, data width

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store presented by MEM stage this cycle
- st_addr  in  AW  store byte address
- st_data  in  DW  store data
- st_ready  out  1  buffer can accept a store: count < DEPTH
- ld_valid  in  1  MEM-stage load lookup this cycle
- ld_addr  in  AW  load byte address
- ld_hit  out  1  a buffered entry matches ld_addr (combinational)
- ld_data  out  DW  data of youngest matching entry; 0 when !ld_hit
- mem_grant  in  1  arbiter permits a new memory write to start (no cache fill active)
- mem_ack  in  1  memory completed the current write (one-cycle pulse)
- mem_en  out  1  memory enable for a buffer write
- mem_wr  out  1  write strobe; equals mem_en
- mem_addr  out  AW  head entry address while mem_en, else 0
- mem_data  out  DW  head entry data while mem_en, else 0
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular FIFO of DEPTH entries {addr, data, valid}, head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Push: on st_valid && st_ready, write {st_addr, st_data} at tail and increment tail. st_valid && !st_ready: store ignored. Upstream must stall on !st_ready.
- Drain FSM, two states:
  - IDLE: mem_en=0. If !empty && mem_grant, go to WRITE next cycle.
  - WRITE: mem_en=mem_wr=1, mem_addr/mem_data = head entry, held stable. On mem_ack, invalidate head, increment head, and return to IDLE. mem_grant is ignored in WRITE; a started write always completes.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, st_ready=0 even if a pop occurs that cycle. st_ready depends only on the registered count.
- Forwarding: compare ld_addr[AW-1:1] against every valid entry's addr[AW-1:1], including the head being written. Youngest (closest to tail) match wins. A store being pushed in the same cycle is not visible to forwarding. ld_hit=0 when !ld_valid.
- Same-address stores: both are kept and drained in order. Forwarding returns the later one.
- mem_ack in IDLE is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, head=tail=0, all valid=0. Outputs after reset: count=0, empty=1, st_ready=1, mem_en=mem_wr=0, mem_addr=mem_data=0, ld_hit=0, ld_data=0.
- Reset during WRITE: mem_en drops with rst_n, and all buffered stores are discarded.
- Push latency: entry is visible in count and forwarding on the cycle after the push edge.
- Drain latency: first mem_en is asserted 1 cycle after the edge on which !empty && mem_grant is sampled. The head pops on the edge where mem_ack=1. A minimum of one IDLE cycle separates consecutive writes.
- With a 4-cycle memory, steady-state throughput is 1 store per (4 + 1) cycles.
- count, empty and st_ready are registered and update on the push/pop edge.

## Test plan
- Reset while holding 2 entries in WRITE -> mem_en=0 immediately, count=0, empty=1, st_ready=1. No further memory write occurs.
- Push 0x0010/0xAAAA with mem_grant=1, ack 4 cycles after mem_en -> mem_en rises 1 cycle after count=1, mem_addr=0x0010, mem_data=0xAAAA held stable, count=0 after ack.
- mem_grant=0, push 4 stores (0x0,0x2,0x4,0x6) -> count=4, st_ready=0. A 5th push is ignored. Raise grant -> drained in order 0x0,0x2,0x4,0x6 with one IDLE cycle between writes.
- Push 0x0020/0x1111 then 0x0020/0x2222, load 0x0021 -> ld_hit=1, ld_data=0x2222. Load 0x0030 -> ld_hit=0, ld_data=0.
- Full buffer with ack and push in the same cycle -> push rejected, count=3. Next cycle push accepted, count=4. With count=2, simultaneous push+ack -> count stays 2.
- Drop mem_grant mid-WRITE -> write held until mem_ack, then FSM stays IDLE while grant=0 with count unchanged.
